// File: rtl/fft_bfly_sequencer.sv
// Address and control sequencer for an in-place radix-2 DIT FFT.
// Each stage issues N/2 butterflies (A/B read addresses plus a twiddle index),
// then idles for the read+butterfly latency so every result of the stage is
// written back before the next stage reads. Write-back addresses follow the
// issued read addresses through a fixed-length delay line.
module fft_bfly_sequencer #(
  parameter int LOG2N    = 3,
  parameter int RD_LAT   = 1,
  parameter int BFLY_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [3:0]       stage,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int L  = RD_LAT + BFLY_LAT;
  localparam int DW = $clog2(L + 1);
  localparam int KW = LOG2N - 1;
  localparam logic [LOG2N-1:0] ONE = {{(LOG2N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state, state_n;
  logic [3:0]      stg, stg_n;
  logic [KW-1:0]   k, k_n;
  logic [DW-1:0]   dcnt, dcnt_n;

  logic [2*LOG2N:0] pipe [L];

  // Low s bits of k are the position inside the group, the rest select the
  // group; A is formed by opening a zero at bit s, B sets that bit.
  function automatic logic [LOG2N-1:0] addr_a_of(input logic [3:0] s, input logic [KW-1:0] kk);
    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] mask;
    kx   = {1'b0, kk};
    mask = (ONE << s) - ONE;
    return ((kx & ~mask) << 1) | (kx & mask);
  endfunction

  function automatic logic [KW-1:0] tw_of(input logic [3:0] s, input logic [KW-1:0] kk);
    logic [LOG2N-1:0] mask;
    logic [KW-1:0]    pos;
    mask = (ONE << s) - ONE;
    pos  = kk & mask[KW-1:0];
    return pos << (4'(KW) - s);
  endfunction

  // State, stage and butterfly/drain counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      stg   <= '0;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      stg   <= stg_n;
      k     <= k_n;
      dcnt  <= dcnt_n;
    end
  end

  // Next-state logic: issue H butterflies, drain L cycles, repeat per stage.
  always_comb begin
    state_n = state;
    stg_n   = stg;
    k_n     = k;
    dcnt_n  = dcnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          stg_n   = '0;
          k_n     = '0;
        end
      end
      ISSUE: begin
        if (k == '1) begin
          state_n = DRAIN;
          dcnt_n  = DW'(L - 1);
        end else begin
          k_n = k + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == '0) begin
          if (stg == 4'(LOG2N - 1)) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            stg_n   = stg + 4'd1;
            k_n     = '0;
          end
        end else begin
          dcnt_n = dcnt - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      stage     <= '0;
    end else begin
      busy  <= (state_n == ISSUE) || (state_n == DRAIN);
      done  <= (state_n == DONE);
      rd_en <= (state_n == ISSUE);
      stage <= ((state_n == ISSUE) || (state_n == DRAIN)) ? stg_n : 4'd0;
      if (state_n == ISSUE) begin
        rd_addr_a <= addr_a_of(stg_n, k_n);
        rd_addr_b <= addr_a_of(stg_n, k_n) | (ONE << stg_n);
        tw_idx    <= tw_of(stg_n, k_n);
      end else begin
        rd_addr_a <= '0;
        rd_addr_b <= '0;
        tw_idx    <= '0;
      end
    end
  end

  // Write-back delay line: an issue appears as a write exactly L cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {wr_en, wr_addr_a, wr_addr_b} = pipe[L-1];

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Scoreboard bench for fft_bfly_sequencer: a reference model schedules the
// expected issues, writes and done pulse of every accepted run; a negedge
// monitor compares whatever the DUT presents against those expectations.
module tb_fft_bfly_sequencer;

  localparam int LOG2N    = 3;
  localparam int RD_LAT   = 1;
  localparam int BFLY_LAT = 4;
  localparam int N        = 1 << LOG2N;
  localparam int H        = N / 2;
  localparam int L        = RD_LAT + BFLY_LAT;
  localparam int RUN      = LOG2N * (H + L);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, rd_en, wr_en;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic [3:0]       stage;

  fft_bfly_sequencer #(.LOG2N(LOG2N), .RD_LAT(RD_LAT), .BFLY_LAT(BFLY_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .stage(stage), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int st;
  } item_t;

  item_t rd_q[$];
  item_t wr_q[$];
  int    cyc = 0;
  int    compared = 0;
  int    mismatched = 0;
  int    run_t0 = 0;
  bit    run_valid = 1'b0;

  // Cycle index: interval n lies between posedge n and posedge n+1.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: full schedule of one run whose first issue is in cycle t0.
  task automatic launch_run(input int t0);
    item_t it;
    for (int s = 0; s < LOG2N; s++) begin
      for (int kk = 0; kk < H; kk++) begin
        int half, pos, grp;
        half  = 1 << s;
        pos   = kk % half;
        grp   = kk / half;
        it.cyc = t0 + s * (H + L) + kk;
        it.a   = grp * 2 * half + pos;
        it.b   = it.a + half;
        it.tw  = pos * (N / (2 * half));
        it.st  = s;
        rd_q.push_back(it);
        it.cyc = it.cyc + L;
        wr_q.push_back(it);
      end
    end
    run_t0    = t0;
    run_valid = 1'b1;
  endtask

  function automatic bit model_idle(input int n);
    return !run_valid || (n > run_t0 + RUN);
  endfunction

  // Drive start for the current cycle; the next edge samples it.
  task automatic apply_stimulus(input bit st_val);
    @(posedge clk);
    #1;
    start = st_val;
    if (st_val && rst_n && model_idle(cyc)) launch_run(cyc + 1);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    rd_q.delete();
    wr_q.delete();
    run_valid = 1'b0;
    repeat (cycles - 1) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step_until(input int n);
    while (cyc < n - 1) apply_stimulus(1'b0);
  endtask

  // Monitor: outputs are sampled mid-cycle and compared with the scoreboard.
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      check_output("reset_outputs_zero",
                   int'({busy, done, rd_en, wr_en, rd_addr_a, rd_addr_b, tw_idx, stage,
                         wr_addr_a, wr_addr_b}), 0);
    end else begin
      check_output("busy", int'(busy),
                   int'(run_valid && cyc >= run_t0 && cyc < run_t0 + RUN));
      check_output("done", int'(done), int'(run_valid && cyc == run_t0 + RUN));
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          check_output("rd_spurious", 1, 0);
        end else begin
          it = rd_q.pop_front();
          check_output("rd_cycle", cyc, it.cyc);
          check_output("rd_addr_a", int'(rd_addr_a), it.a);
          check_output("rd_addr_b", int'(rd_addr_b), it.b);
          check_output("tw_idx", int'(tw_idx), it.tw);
          check_output("stage", int'(stage), it.st);
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        it = rd_q.pop_front();
        check_output("rd_missing", 0, 1);
      end
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          check_output("wr_spurious", 1, 0);
        end else begin
          it = wr_q.pop_front();
          check_output("wr_cycle", cyc, it.cyc);
          check_output("wr_addr_a", int'(wr_addr_a), it.a);
          check_output("wr_addr_b", int'(wr_addr_b), it.b);
        end
      end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
        it = wr_q.pop_front();
        check_output("wr_missing", 0, 1);
      end
    end
  end

  initial begin
    int t0;
    bit hold;
    $display("[TB] start");
    do_reset(3);
    repeat (2) apply_stimulus(1'b0);

    // Single run with start pulses during stage-1 issue and during done.
    apply_stimulus(1'b1);
    t0 = run_t0;
    apply_stimulus(1'b0);
    step_until(t0 + H + L + 1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    step_until(t0 + RUN);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    repeat (6) apply_stimulus(1'b0);

    // start held high launches back-to-back runs.
    repeat (2 * RUN + 6) apply_stimulus(1'b1);
    repeat (RUN + L + 4) apply_stimulus(1'b0);

    // Reset during stage-1 drain, then a clean run.
    apply_stimulus(1'b1);
    t0 = run_t0;
    apply_stimulus(1'b0);
    step_until(t0 + H + L + H + 1);
    do_reset(3);
    repeat (L + 3) apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    repeat (RUN + L + 4) apply_stimulus(1'b0);

    // Randomized start activity with occasional resets.
    hold = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        if ($urandom_range(0, 39) == 0) hold = ~hold;
        apply_stimulus(hold || ($urandom_range(0, 9) == 0));
      end
    end

    repeat (RUN + L + 6) apply_stimulus(1'b0);
    check_output("leftover_rd", rd_q.size(), 0);
    check_output("leftover_wr", wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fft_bfly_sequencer.md
Name: fft_bfly_sequencer

Overview:
- Control/address engine that drives the radix-2 DIT butterfly datapath for an in-place N-point FFT, N = 2^LOG2N.
- Per stage it issues A/B read addresses and a twiddle index into a dual-port sample RAM, twiddle ROM and butterfly.
- It generates the write-back addresses for the X/Y results after the read plus butterfly pipeline latency.
- It is the producer/consumer end of the butterfly operand/result interface. It carries no sample data itself.
- Input samples must already be in bit-reversed order in RAM.

Parameters:
- LOG2N, 3, log2 of FFT length; legal range 2..10.
- RD_LAT, 1, cycles from rd_en/addresses to RAM data and twiddle ROM data valid at butterfly inputs.
- BFLY_LAT, 4, butterfly input-to-output latency in clocks.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a full FFT run; sampled only in IDLE.
- busy  out  1  high while a run is in progress (ISSUE or DRAIN).
- done  out  1  one-cycle pulse when the run completes.
- rd_en  out  1  operand issue strobe.
- rd_addr_a  out  LOG2N  RAM address of operand A.
- rd_addr_b  out  LOG2N  RAM address of operand B.
- tw_idx  out  LOG2N-1  twiddle ROM index k, selecting W_N^k.
- stage  out  4  current stage number, 0..LOG2N-1.
- wr_en  out  1  result write strobe (X to wr_addr_a, Y to wr_addr_b).
- wr_addr_a  out  LOG2N  write address for X.
- wr_addr_b  out  LOG2N  write address for Y.

Behaviour:
- Reset: async, active-low. While rst_n=0, all outputs are 0, state=IDLE, stage/butterfly counters are 0, and the delay line is cleared.
- Outputs: all outputs are registered.
- Reset mid-run: abandons the run immediately. No wr_en is asserted after reset release until a new run starts.
- Definitions: L = RD_LAT + BFLY_LAT (default 5). H = N/2 butterflies per stage.
- State IDLE: busy=0, rd_en=0. If start=1 at a clock edge, go to ISSUE with stage=0, k=0.
- State ISSUE: one butterfly per cycle, rd_en=1, k = 0..H-1. Address generation for stage s and butterfly k:
  - half = 1<<s
  - pos = k & (half-1)
  - grp = k>>s
  - rd_addr_a = grp*2*half + pos
  - rd_addr_b = rd_addr_a + half
  - tw_idx = pos << (LOG2N-1-s)
  - After k=H-1, go to DRAIN with a drain counter of L.
- State DRAIN: rd_en=0 for exactly L cycles, so all writes of the stage land before the next stage reads (RAW hazard guard).
  - Exit to ISSUE with stage+1 and k=0 if stage < LOG2N-1.
  - Otherwise exit to DONE.
- State DONE: one cycle, done=1, busy=0. Next state is IDLE.
- busy: 1 in ISSUE and DRAIN only.
- Write-back delay line: depth L, carrying {valid, addr_a, addr_b}.
  - An issue in cycle c produces wr_en=1 in cycle c+L with wr_addr_a/b equal to the issued rd_addr_a/b.
  - wr_en is never asserted in any other cycle.
- RAM hazard: the last write of a stage occurs in the final DRAIN cycle, and the first read of the next stage is issued the cycle after. The RAM must be write-before-read across that edge (standard synchronous RAM).
- start handling:
  - start while busy or in DONE is ignored (no queueing).
  - start held high continuously launches a new run in the cycle after DONE returns to IDLE.
- Run length: run time from start edge to the done pulse is LOG2N*(H+L) busy cycles. Default: 3*(4+5) = 27.

Test Plan:
- Reset then start pulse, LOG2N=3 -> stage0 issues (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0 on 4 consecutive cycles. busy=1. Then 5 cycles with rd_en=0.
- Same run -> stage1 issues (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2. Stage2 issues (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3. done is high exactly once, 27 cycles after busy rises. busy=0 during the done cycle.
- Write-back check -> every rd_en at cycle c is matched by wr_en at c+5 with the same address pair. Exactly 12 writes per run. No wr_en outside those cycles.
- Integrated with butterfly + RAM, 8-point impulse x[0]=0x4000, others 0 -> all 8 outputs equal and match the golden model scaled by the butterfly's per-stage scaling, within ±1 LSB.
- start pulsed during ISSUE of stage1 and during DONE -> ignored. The run completes at cycle 27 and the next run starts only on a later start in IDLE.
- rst_n dropped during stage1 DRAIN, released 3 cycles later -> all outputs 0 immediately. No wr_en after release. A new start yields a full clean 27-cycle run.
